// File: rtl/pulse_multiplier_pkg.sv
// rtl/pulse_multiplier_pkg.sv - shared types and helpers for the pulse multiplier
package pulse_multiplier_pkg;

  typedef enum logic [1:0] {
    PEND_HOLD,
    PEND_INC,
    PEND_DEC,
    PEND_DROP
  } pend_op_t;

  typedef struct packed {
    logic load;
    logic dec;
  } cnt_ctrl_t;

  // An arrival and a consumption in the same cycle cancel out; a lone arrival
  // against a full counter is lost.
  function automatic pend_op_t pend_op(input logic arrival, input logic consume,
                                       input logic at_max);
    pend_op_t op;
    op = PEND_HOLD;
    if (arrival && !consume) begin
      op = at_max ? PEND_DROP : PEND_INC;
    end else if (consume && !arrival) begin
      op = PEND_DEC;
    end
    return op;
  endfunction

endpackage

// File: rtl/pulse_multiplier_counter.sv
// rtl/pulse_multiplier_counter.sv - loadable binary down counter
module pulse_multiplier_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Load wins over decrement so a fresh value is never disturbed on its first cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/pulse_multiplier.sv
// rtl/pulse_multiplier.sv - expands each queued request into a spaced burst of output pulses
module pulse_multiplier
  import pulse_multiplier_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int PENDING_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pulses_in,
  input  logic [WORD_WIDTH-1:0] multiplier,
  input  logic [WORD_WIDTH-1:0] spacing,
  output logic                  pulse_out,
  output logic                  busy,
  output logic                  dropped
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [PENDING_WIDTH-1:0] pending;
  logic [WORD_WIDTH-1:0]    gap_len;
  logic [WORD_WIDTH-1:0]    remaining;
  logic [WORD_WIDTH-1:0]    gap_cnt;
  logic                     consume;
  logic                     last_pulse;
  logic                     gap_done;
  pend_op_t                 op;
  cnt_ctrl_t                rem_ctrl;
  cnt_ctrl_t                gap_ctrl;

  assign consume    = (state == IDLE) && (pending != '0);
  assign op         = pend_op(pulses_in, consume, &pending);
  assign last_pulse = (remaining == WORD_WIDTH'(1));
  assign gap_done   = (gap_cnt <= WORD_WIDTH'(1));
  assign busy       = (state != IDLE) || (pending != '0);

  always_comb begin
    state_next = state;
    rem_ctrl   = '0;
    gap_ctrl   = '0;
    case (state)
      IDLE: begin
        if (consume) begin
          rem_ctrl.load = 1'b1;
          if (multiplier != '0) begin
            state_next = PULSE;
          end
        end
      end
      PULSE: begin
        // Gap counter is reloaded every pulse so it is fresh on entry to GAP.
        rem_ctrl.dec  = 1'b1;
        gap_ctrl.load = 1'b1;
        if (gap_len != '0) begin
          state_next = GAP;
        end else if (last_pulse) begin
          state_next = IDLE;
        end
      end
      GAP: begin
        gap_ctrl.dec = 1'b1;
        if (gap_done) begin
          state_next = (remaining != '0) ? PULSE : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      gap_len   <= '0;
      pulse_out <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_next;
      pulse_out <= (state_next == PULSE);
      dropped   <= (op == PEND_DROP);
      if (consume) begin
        gap_len <= spacing;
      end
      case (op)
        PEND_INC: pending <= pending + PENDING_WIDTH'(1);
        PEND_DEC: pending <= pending - PENDING_WIDTH'(1);
        default:  pending <= pending;
      endcase
    end
  end

  pulse_multiplier_counter #(
    .WIDTH(WORD_WIDTH)
  ) u_remaining (
    .clock      (clock),
    .reset      (reset),
    .load       (rem_ctrl.load),
    .load_value (multiplier),
    .enable     (rem_ctrl.dec),
    .count      (remaining)
  );

  pulse_multiplier_counter #(
    .WIDTH(WORD_WIDTH)
  ) u_gap (
    .clock      (clock),
    .reset      (reset),
    .load       (gap_ctrl.load),
    .load_value (gap_len),
    .enable     (gap_ctrl.dec),
    .count      (gap_cnt)
  );

endmodule

// File: tb/tb_pulse_multiplier.sv
// tb/tb_pulse_multiplier.sv - self-checking bench for pulse_multiplier
module tb_pulse_multiplier;

  localparam int WW = 8;
  localparam int PW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          pulses_in;
  logic [WW-1:0] multiplier;
  logic [WW-1:0] spacing;
  logic          pulse_out;
  logic          busy;
  logic          dropped;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pulse_multiplier #(
    .WORD_WIDTH   (WW),
    .PENDING_WIDTH(PW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pulses_in  (pulses_in),
    .multiplier (multiplier),
    .spacing    (spacing),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .dropped    (dropped)
  );

  typedef struct {
    logic          pin;
    logic [WW-1:0] mult;
    logic [WW-1:0] spc;
    logic          pulse;
    logic          bsy;
    int            pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic pin, input int m, input int s,
                              input logic p, input logic b, input int pe);
    vec_t v;
    v.pin   = pin;
    v.mult  = WW'(m);
    v.spc   = WW'(s);
    v.pulse = p;
    v.bsy   = b;
    v.pend  = pe;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic p, input logic [WW-1:0] m, input logic [WW-1:0] s);
    pulses_in  = p;
    multiplier = m;
    spacing    = s;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int drops;
    int maxp;
    int first_drop;
    int first_p;
    int last_p;
    int idle_at;
    int b_start;
    int b_g;
    int pend_m;
    logic drop_m;

    // Scenario A: 3 pulses back to back
    add(1, 3, 0, 0, 0, 0); add(0, 3, 0, 0, 1, 1);
    add(0, 3, 0, 1, 1, 0); add(0, 3, 0, 1, 1, 0); add(0, 3, 0, 1, 1, 0);
    add(0, 3, 0, 0, 0, 0); add(0, 3, 0, 0, 0, 0);
    // Scenario B: 2 pulses spaced by 2; inputs change mid-burst
    add(1, 2, 2, 0, 0, 0); add(0, 2, 2, 0, 1, 1);
    add(0, 7, 0, 1, 1, 0); add(0, 7, 0, 0, 1, 0); add(0, 7, 0, 0, 1, 0);
    add(0, 7, 0, 1, 1, 0); add(0, 7, 0, 0, 1, 0); add(0, 7, 0, 0, 1, 0);
    add(0, 7, 0, 0, 0, 0); add(0, 7, 0, 0, 0, 0);
    // Scenario C: two requests, multiplier 2, spacing 1
    add(1, 2, 1, 0, 0, 0); add(1, 2, 1, 0, 1, 1);
    add(0, 2, 1, 1, 1, 1); add(0, 2, 1, 0, 1, 1); add(0, 2, 1, 1, 1, 1);
    add(0, 2, 1, 0, 1, 1); add(0, 2, 1, 0, 1, 1);
    add(0, 2, 1, 1, 1, 0); add(0, 2, 1, 0, 1, 0); add(0, 2, 1, 1, 1, 0);
    add(0, 2, 1, 0, 1, 0); add(0, 2, 1, 0, 0, 0); add(0, 2, 1, 0, 0, 0);
    // Scenario D: multiplier 0 consumes silently
    add(1, 0, 3, 0, 0, 0); add(0, 0, 3, 0, 1, 1);
    add(0, 0, 3, 0, 0, 0); add(0, 0, 3, 0, 0, 0);

    reset = 1'b1;
    drive(1'b0, '0, '0);
    next_cycle();
    check("reset pulse_out", int'(pulse_out), 0);
    check("reset busy", int'(busy), 0);
    check("reset dropped", int'(dropped), 0);
    check("reset pending", int'(dut.pending), 0);
    next_cycle();
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].pin, vecs[i].mult, vecs[i].spc);
      @(negedge clock);
      check($sformatf("vec%0d pulse_out", i), int'(pulse_out), int'(vecs[i].pulse));
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].bsy));
      check($sformatf("vec%0d pending", i), int'(dut.pending), vecs[i].pend);
      check($sformatf("vec%0d dropped", i), int'(dropped), 0);
      next_cycle();
    end

    // Saturation: 6 requests into a 3-deep pending counter
    pulses = 0; drops = 0; maxp = 0; first_drop = -1;
    for (int c = 0; c < 40; c++) begin
      drive(c < 6, WW'(4), WW'(0));
      @(negedge clock);
      if (pulse_out) pulses++;
      if (dropped) begin
        drops++;
        if (first_drop < 0) first_drop = c;
      end
      if (int'(dut.pending) > maxp) maxp = int'(dut.pending);
      next_cycle();
    end
    check("sat max pending", maxp, 3);
    check("sat drop count", drops, 2);
    check("sat first drop cycle", first_drop, 5);
    check("sat pulse count", pulses, 16);
    check("sat busy at end", int'(busy), 0);

    // Asynchronous reset in the middle of a burst
    drive(1'b1, WW'(5), WW'(0));
    next_cycle();
    next_cycle();
    drive(1'b0, WW'(5), WW'(0));
    @(negedge clock);
    check("mid pulse before reset", int'(pulse_out), 1);
    check("mid pending before reset", int'(dut.pending), 1);
    reset = 1'b1;
    #1;
    check("async reset pulse_out", int'(pulse_out), 0);
    check("async reset busy", int'(busy), 0);
    check("async reset pending", int'(dut.pending), 0);
    next_cycle();
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (pulse_out || busy) pulses++;
      next_cycle();
    end
    check("after reset activity", pulses, 0);

    // Largest multiplier must run its full count without wrapping
    pulses = 0; first_p = -1; last_p = -1;
    drive(1'b1, WW'(255), WW'(0));
    for (int c = 0; c < 270; c++) begin
      if (c == 1) drive(1'b0, WW'(255), WW'(0));
      @(negedge clock);
      if (pulse_out) begin
        pulses++;
        if (first_p < 0) first_p = c;
        last_p = c;
      end
      next_cycle();
    end
    check("max mult pulse count", pulses, 255);
    check("max mult first pulse", first_p, 2);
    check("max mult last pulse", last_p, 256);
    check("max mult busy at end", int'(busy), 0);

    // Randomized traffic against an arithmetic schedule model
    do_reset();
    idle_at = 0; b_start = 0; b_g = 0; pend_m = 0; drop_m = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic p;
      logic consume;
      int m;
      int s;
      int exp_p;
      int exp_b;
      p = ($urandom_range(0, ((c / 300) % 2 == 1) ? 1 : 5) == 0);
      m = int'($urandom_range(0, 4));
      s = int'($urandom_range(0, 3));
      drive(p, WW'(m), WW'(s));
      @(negedge clock);
      exp_p = ((c >= b_start) && (c < idle_at) && ((c - b_start) % (b_g + 1) == 0)) ? 1 : 0;
      exp_b = ((c < idle_at) || (pend_m > 0)) ? 1 : 0;
      check($sformatf("rand c%0d pulse_out", c), int'(pulse_out), exp_p);
      check($sformatf("rand c%0d busy", c), int'(busy), exp_b);
      check($sformatf("rand c%0d dropped", c), int'(dropped), int'(drop_m));
      consume = (c >= idle_at) && (pend_m > 0);
      drop_m  = p && !consume && (pend_m == 3);
      if (consume) begin
        b_start = c + 1;
        b_g     = s;
        idle_at = c + 1 + m * (s + 1);
        pend_m--;
      end
      if (p && !drop_m) pend_m++;
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
